// File: rtl/counter_event_capture_if.sv
// Bus between the counter stage, the capture block and the readout logic.
// Entry width is 16 bits when CAPTURE_TAG_EN is defined, otherwise 8.
interface counter_event_capture_if #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 8
);
  localparam int CW = $clog2(DEPTH) + 1;
`ifdef CAPTURE_TAG_EN
  localparam int DW = 2 * CNT_W;
`else
  localparam int DW = CNT_W;
`endif

  logic [CNT_W-1:0] count_in;
  logic             count_valid;
  logic             cfg_load;
  logic [CNT_W-1:0] cfg_data;
  logic             event_in;
  logic             rd_en;
  logic             ovf_clr;
  logic [DW-1:0]    fifo_dout;
  logic             fifo_empty;
  logic             fifo_full;
  logic [CW-1:0]    fifo_count;
  logic             overflow;
  logic             match_pulse;
  logic             pwm_out;

  modport master (
    output count_in, count_valid, cfg_load, cfg_data, event_in, rd_en, ovf_clr,
    input  fifo_dout, fifo_empty, fifo_full, fifo_count, overflow, match_pulse, pwm_out
  );

  modport slave (
    input  count_in, count_valid, cfg_load, cfg_data, event_in, rd_en, ovf_clr,
    output fifo_dout, fifo_empty, fifo_full, fifo_count, overflow, match_pulse, pwm_out
  );
endinterface

// File: rtl/counter_event_capture.sv
// Timestamps synchronized event edges into a show-ahead FIFO and compares the count
// against a threshold. Define CAPTURE_TAG_EN to prefix entries with a wrap counter.
module counter_event_capture #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 8
) (
  input logic                    clk,
  input logic                    rst,
  counter_event_capture_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
`ifdef CAPTURE_TAG_EN
  localparam int DW = 2 * CNT_W;
`else
  localparam int DW = CNT_W;
`endif
  localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

  logic             r_s1, r_s2, r_prev;
  logic [DW-1:0]    r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr, r_rd_ptr;
  logic [AW:0]      r_count;
  logic             r_overflow;
  logic [CNT_W-1:0] r_cmp;
  logic             r_match, r_pwm;

  logic             w_capture, w_full, w_empty, w_wr, w_rd, w_drop;
  logic [DW-1:0]    w_entry;

  // Event line crosses in through two flops; prev turns the level into a one-shot.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1   <= 1'b0;
      r_s2   <= 1'b0;
      r_prev <= 1'b0;
    end else begin
      r_s1   <= bus.event_in;
      r_s2   <= r_s1;
      r_prev <= r_s2;
    end
  end

  always_comb begin
    w_capture = r_s2 & ~r_prev;
    w_empty   = (r_count == '0);
    w_full    = (r_count == FULL_CNT);
    w_rd      = bus.rd_en & ~w_empty;
    w_wr      = w_capture & (~w_full | w_rd);
    w_drop    = w_capture & w_full & ~w_rd;
  end

`ifdef CAPTURE_TAG_EN
  logic [CNT_W-1:0] r_wrap_cnt, r_prev_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wrap_cnt <= '0;
      r_prev_cnt <= '0;
    end else if (bus.count_valid) begin
      r_prev_cnt <= bus.count_in;
      if (r_prev_cnt == '1 && bus.count_in == '0) r_wrap_cnt <= r_wrap_cnt + 1'b1;
    end
  end

  assign w_entry = {r_wrap_cnt, bus.count_in};
`else
  assign w_entry = bus.count_in;
`endif

  // NOTE: storage is not reset; the output mux forces zero while empty, so stale
  // entries are never visible and the array can map onto plain register/RAM cells.
  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wr_ptr] <= w_entry;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_wr) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_rd) r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_wr, w_rd})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      // A fresh drop wins over a clear in the same cycle.
      if (w_drop)           r_overflow <= 1'b1;
      else if (bus.ovf_clr) r_overflow <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cmp   <= 8'h80;
      r_match <= 1'b0;
      r_pwm   <= 1'b0;
    end else begin
      if (bus.cfg_load) r_cmp <= bus.cfg_data;
      r_match <= bus.count_valid & (bus.count_in == r_cmp);
      r_pwm   <= (bus.count_in < r_cmp);
    end
  end

  assign bus.fifo_dout   = w_empty ? '0 : r_mem[r_rd_ptr];
  assign bus.fifo_empty  = w_empty;
  assign bus.fifo_full   = w_full;
  assign bus.fifo_count  = r_count;
  assign bus.overflow    = r_overflow;
  assign bus.match_pulse = r_match;
  assign bus.pwm_out     = r_pwm;
endmodule

// File: tb/tb_counter_event_capture.sv
// Scoreboard bench for counter_event_capture: expected captures are queued when an
// event is driven and compared as the FIFO is popped. Honours CAPTURE_TAG_EN.
module tb_counter_event_capture;
  localparam int DEPTH = 4;
`ifdef CAPTURE_TAG_EN
  localparam int DW = 16;
`else
  localparam int DW = 8;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  counter_event_capture_if #(.DEPTH(DEPTH), .CNT_W(8)) bus ();

  counter_event_capture #(.DEPTH(DEPTH), .CNT_W(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int            n_tests = 0;
  int            n_fail  = 0;
  int            ramp_pos = 0;
  bit            ramp_on  = 1'b0;
  bit            exp_ovf  = 1'b0;
  logic [DW-1:0] q [$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Entry the counter stream should yield when it sits at ramp position p.
  function automatic logic [DW-1:0] exp_entry(input int p);
`ifdef CAPTURE_TAG_EN
    int w;
    w = (p > 0) ? (p - 1) / 256 : 0;
    return {w[7:0], p[7:0]};
`else
    return p[7:0];
`endif
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
    if (ramp_on) begin
      ramp_pos++;
      bus.count_in = ramp_pos[7:0];
    end
  endtask

  task automatic do_reset();
    ramp_on         = 1'b0;
    ramp_pos        = 0;
    bus.count_in    = 8'h00;
    bus.count_valid = 1'b1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst     = 1'b0;
    exp_ovf = 1'b0;
    q.delete();
    ramp_on = 1'b1;
  endtask

  task automatic fire_event(input int hold, input int gap);
    if (q.size() < DEPTH) q.push_back(exp_entry(ramp_pos + 2));
    else                  exp_ovf = 1'b1;
    bus.event_in = 1'b1;
    repeat (hold) tick();
    bus.event_in = 1'b0;
    repeat (gap) tick();
  endtask

  task automatic pop_compare(input string tag);
    check(tag, bus.fifo_dout, q.pop_front());
    bus.rd_en = 1'b1;
    tick();
    bus.rd_en = 1'b0;
  endtask

  initial begin
    int            v;
    int            hi, n_match, match_idx;
    int            thr_tab [4];
    logic [7:0]    thr8;

    bus.count_in    = '0;
    bus.count_valid = 1'b0;
    bus.cfg_load    = 1'b0;
    bus.cfg_data    = '0;
    bus.event_in    = 1'b0;
    bus.rd_en       = 1'b0;
    bus.ovf_clr     = 1'b0;

    // Reset state
    do_reset();
    check("rst_empty", bus.fifo_empty, 1);
    check("rst_full", bus.fifo_full, 0);
    check("rst_count", bus.fifo_count, 0);
    check("rst_ovf", bus.overflow, 0);
    check("rst_pwm", bus.pwm_out, 0);
    check("rst_match", bus.match_pulse, 0);
    check("rst_dout", bus.fifo_dout, 0);

    // Single capture, event first sampled at edge 10, level held 20 cycles
    repeat (9) tick();
    fire_event(20, 3);
    check("lvl_one_entry", bus.fifo_count, 1);
    check("lvl_value", bus.fifo_dout[7:0], 8'd11);
    pop_compare("lvl_head");
    check("lvl_empty", bus.fifo_empty, 1);

    // Five events into a four-deep FIFO without reads
    for (int i = 0; i < 5; i++) fire_event(2, 3);
    check("ovf_full", bus.fifo_full, 1);
    check("ovf_count", bus.fifo_count, DEPTH);
    check("ovf_flag", bus.overflow, exp_ovf);
    check("ovf_head", bus.fifo_dout, q[0]);
    bus.ovf_clr = 1'b1;
    tick();
    bus.ovf_clr = 1'b0;
    exp_ovf = 1'b0;
    check("ovf_clr", bus.overflow, 0);
    check("ovf_clr_count", bus.fifo_count, DEPTH);

    // Capture coinciding with a read while full
    v = ramp_pos;
    bus.event_in = 1'b1;
    tick();
    tick();
    bus.rd_en = 1'b1;
    check("wr_rd_full_head", bus.fifo_dout, q.pop_front());
    q.push_back(exp_entry(v + 2));
    tick();
    bus.rd_en    = 1'b0;
    bus.event_in = 1'b0;
    check("wr_rd_full_count", bus.fifo_count, DEPTH);
    check("wr_rd_full_flag", bus.fifo_full, 1);
    check("wr_rd_full_ovf", bus.overflow, 0);
    check("wr_rd_full_next", bus.fifo_dout, q[0]);
    repeat (3) tick();
    while (q.size() > 0) pop_compare("drain_head");
    check("drain_empty", bus.fifo_empty, 1);
    check("drain_count", bus.fifo_count, 0);
    check("drain_dout", bus.fifo_dout, 0);

    // Read on empty is ignored
    bus.rd_en = 1'b1;
    tick();
    bus.rd_en = 1'b0;
    check("rd_empty_count", bus.fifo_count, 0);

    // Capture coinciding with a read while empty
    v = ramp_pos;
    bus.event_in = 1'b1;
    tick();
    tick();
    bus.rd_en = 1'b1;
    q.push_back(exp_entry(v + 2));
    tick();
    bus.rd_en    = 1'b0;
    bus.event_in = 1'b0;
    check("wr_rd_empty_count", bus.fifo_count, 1);
    pop_compare("wr_rd_empty_head");
    repeat (3) tick();

    // Reset mid-operation discards contents
    fire_event(2, 3);
    check("pre_rst_count", bus.fifo_count, 1);
    do_reset();
    check("mid_rst_empty", bus.fifo_empty, 1);
    check("mid_rst_count", bus.fifo_count, 0);

    // Compare/PWM sweep; first row uses the reset threshold
    ramp_on    = 1'b0;
    thr_tab    = '{128, 64, 0, 255};
    for (int k = 0; k < 4; k++) begin
      thr8 = thr_tab[k][7:0];
      if (k > 0) begin
        bus.cfg_load = 1'b1;
        bus.cfg_data = thr8;
        tick();
        bus.cfg_load = 1'b0;
      end
      hi = 0;
      n_match = 0;
      match_idx = -1;
      bus.count_in = 8'h00;
      for (int i = 0; i < 256; i++) begin
        tick();
        if (bus.pwm_out) hi++;
        if (bus.match_pulse) begin
          n_match++;
          match_idx = i;
        end
        bus.count_in = 8'(i + 1);
      end
      check($sformatf("pwm_hi_%0h", thr8), hi, thr_tab[k]);
      check($sformatf("match_cnt_%0h", thr8), n_match, 1);
      check($sformatf("match_at_%0h", thr8), match_idx, thr_tab[k]);
    end
    bus.count_in    = thr8;
    bus.count_valid = 1'b0;
    tick();
    check("match_needs_valid", bus.match_pulse, 0);
    bus.count_valid = 1'b1;

`ifdef CAPTURE_TAG_EN
    // Two wraps then an event at count 0x05
    do_reset();
    repeat (32'h203) tick();
    fire_event(3, 3);
    check("tag_value", bus.fifo_dout, 16'h0205);
    pop_compare("tag_head");
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
